// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter
// ---------------------------------------------------------------------------
// Two-port round-robin arbiter that shares one SDRAM controller between two
// masters. Port 1 is a read-only streaming fetcher. Port 2 is the CPU and
// issues reads and writes.
//
// Operation:
//   - IDLE: grant one port. When both ports request, the port that was not
//     granted last wins.
//   - READ / WRITE: hold the controller request, address and write data
//     stable until the matching completion pulse arrives.
//   - RECOVER: lasts one cycle. The master sees its completion pulse here.
//     Requests are ignored so the master can drop its request.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   addr1, req_read1           port 1 read request (level)
//   data1, data_valid1         port 1 read data and completion pulse
//   addr2, data_in2            port 2 address and write data
//   req_read2, req_write2      port 2 requests (level); write has priority
//   data_out2, data_valid2     port 2 read data and completion pulse
//   write_complete2            port 2 write completion pulse
//   dram_addr, dram_data_in    address and write data to the controller
//   dram_req_read/_write       controller requests (level)
//   dram_data_out              read data from the controller
//   dram_data_out_valid        controller read-done pulse
//   dram_write_complete        controller write-done pulse
//   busy                       high whenever the state is not IDLE
//   timeout_err                sticky timeout flag (only with the macro below)
//
// Optional build macro DRAM_ARB_TIMEOUT_EN:
//   Aborts a transaction that is not completed within TIMEOUT cycles.
//   A timed-out read returns 32'hDEADBEEF.
// ---------------------------------------------------------------------------
module dram_rr_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              req_read1,
  output logic [DATA_W-1:0] data1,
  output logic              data_valid1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data_in2,
  input  logic              req_read2,
  input  logic              req_write2,
  output logic [DATA_W-1:0] data_out2,
  output logic              data_valid2,
  output logic              write_complete2,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_data_in,
  output logic              dram_req_read,
  output logic              dram_req_write,
  input  logic [DATA_W-1:0] dram_data_out,
  input  logic              dram_data_out_valid,
  input  logic              dram_write_complete,
`ifdef DRAM_ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                port2_q, port2_d;      // granted port is port 2
  logic                last2_q, last2_d;      // last completed grant was port 2
  logic                req_rd_q, req_rd_d;
  logic                req_wr_q, req_wr_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [DATA_W-1:0]   data2_q, data2_d;
  logic                dv1_q, dv1_d;
  logic                dv2_q, dv2_d;
  logic                wc2_q, wc2_d;
  logic                busy_q, busy_d;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The counter is 0 on the first cycle after the grant. A value of
  // TIMEOUT-1 therefore marks the last cycle of waiting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;
`endif

  logic                want1, want2, pick2, done;
  logic [DATA_W-1:0]   rd_val;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    port2_d  = port2_q;
    last2_d  = last2_q;
    req_rd_d = req_rd_q;
    req_wr_d = req_wr_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    dv1_d    = 1'b0;
    dv2_d    = 1'b0;
    wc2_d    = 1'b0;
    done     = 1'b0;
    rd_val   = dram_data_out;
`ifdef DRAM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = terr_q;
`endif

    want1 = req_read1;
    want2 = req_read2 | req_write2;
    // Port 2 wins only when port 1 is silent or port 1 was served last.
    pick2 = want2 & (~want1 | ~last2_q);

    case (state_q)
      IDLE: begin
        if (want1 | want2) begin
          port2_d = pick2;
`ifdef DRAM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (pick2) begin
            addr_d  = addr2;
            wdata_d = data_in2;
            if (req_write2) begin
              req_wr_d = 1'b1;
              state_d  = WRITE;
            end else begin
              req_rd_d = 1'b1;
              state_d  = READ;
            end
          end else begin
            addr_d   = addr1;
            req_rd_d = 1'b1;
            state_d  = READ;
          end
        end
      end
      READ: begin
        if (dram_data_out_valid) begin
          done = 1'b1;
        end
`ifdef DRAM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          done   = 1'b1;
          rd_val = DATA_W'(32'hDEADBEEF);
          terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WRITE: begin
        if (dram_write_complete) begin
          done = 1'b1;
        end
`ifdef DRAM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          done   = 1'b1;
          terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion: drop the controller request. Capture the read data.
    // Arm the one-cycle master pulse, which shows during RECOVER.
    if (done) begin
      req_rd_d = 1'b0;
      req_wr_d = 1'b0;
      last2_d  = port2_q;
      state_d  = RECOVER;
      if (state_q == WRITE) begin
        wc2_d = 1'b1;
      end else if (port2_q) begin
        data2_d = rd_val;
        dv2_d   = 1'b1;
      end else begin
        data1_d = rd_val;
        dv1_d   = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      port2_q  <= 1'b0;
      last2_q  <= 1'b1;
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      data1_q  <= '0;
      data2_q  <= '0;
      dv1_q    <= 1'b0;
      dv2_q    <= 1'b0;
      wc2_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DRAM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      port2_q  <= port2_d;
      last2_q  <= last2_d;
      req_rd_q <= req_rd_d;
      req_wr_q <= req_wr_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      dv1_q    <= dv1_d;
      dv2_q    <= dv2_d;
      wc2_q    <= wc2_d;
      busy_q   <= busy_d;
`ifdef DRAM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign data1           = data1_q;
  assign data_valid1     = dv1_q;
  assign data_out2       = data2_q;
  assign data_valid2     = dv2_q;
  assign write_complete2 = wc2_q;
  assign dram_addr       = addr_q;
  assign dram_data_in    = wdata_q;
  assign dram_req_read   = req_rd_q;
  assign dram_req_write  = req_wr_q;
  assign busy            = busy_q;
`ifdef DRAM_ARB_TIMEOUT_EN
  assign timeout_err     = terr_q;
`endif

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Testbench for dram_rr_arbiter. The bench plays the SDRAM controller.
// It applies a table of single transactions, then runs the multi-cycle
// corner sequences. Master completion pulses are checked against a
// scoreboard queue.
module tb_dram_rr_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr1 = '0, addr2 = '0;
  logic          req_read1 = 1'b0, req_read2 = 1'b0, req_write2 = 1'b0;
  logic [DW-1:0] data_in2 = '0;
  logic [DW-1:0] data1, data_out2;
  logic          data_valid1, data_valid2, write_complete2;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_data_in;
  logic          dram_req_read, dram_req_write;
  logic [DW-1:0] dram_data_out = '0;
  logic          dram_data_out_valid = 1'b0, dram_write_complete = 1'b0;
  logic          busy;
`ifdef DRAM_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  dram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .addr1(addr1), .req_read1(req_read1), .data1(data1), .data_valid1(data_valid1),
    .addr2(addr2), .data_in2(data_in2), .req_read2(req_read2), .req_write2(req_write2),
    .data_out2(data_out2), .data_valid2(data_valid2), .write_complete2(write_complete2),
    .dram_addr(dram_addr), .dram_data_in(dram_data_in),
    .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_out(dram_data_out), .dram_data_out_valid(dram_data_out_valid),
    .dram_write_complete(dram_write_complete),
`ifdef DRAM_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // kind: 1 = port 1 read, 2 = port 2 read, 3 = port 2 write
  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            delay;
    bit            noise;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [DW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  // Check any master pulse seen this cycle against the scoreboard head.
  task automatic observe();
    exp_t e;
    logic [2:0] got, want;
    got = {data_valid1, data_valid2, write_complete2};
    if (got != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {61'd0, got}, 64'd0);
      end else begin
        e = sb.pop_front();
        want = (e.kind == 2'd1) ? 3'b100 : (e.kind == 2'd2) ? 3'b010 : 3'b001;
        $display("txn kind=%0d pulses=%b data1=%08h data_out2=%08h", e.kind, got, data1, data_out2);
        chk("pulse_kind", {61'd0, got}, {61'd0, want});
        if (e.kind == 2'd1) chk("data1", {32'd0, data1}, {32'd0, e.data});
        if (e.kind == 2'd2) chk("data_out2", {32'd0, data_out2}, {32'd0, e.data});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  // Controller model. It waits for a request, then holds it for 'delay'
  // cycles. Then it returns the matching completion pulse.
  task automatic serve(input int delay, input logic [DW-1:0] rdata, input bit noise,
                       output int t, output logic [AW-1:0] a, output logic w,
                       output logic [DW-1:0] din);
    logic r;
    t = 0;
    while (!(dram_req_read || dram_req_write) && t < 20) begin
      tick();
      t++;
    end
    chk("req_seen", {63'd0, t < 20}, 64'd1);
    a = dram_addr;
    w = dram_req_write;
    r = dram_req_read;
    din = dram_data_in;
    for (int k = 0; k < delay; k++) begin
      if (noise && k == 0) begin
        if (w) dram_data_out_valid = 1'b1;
        else   dram_write_complete = 1'b1;
      end
      tick();
      dram_data_out_valid = 1'b0;
      dram_write_complete = 1'b0;
      chk("req_hold", {6'd0, r, w, a, din}, {6'd0, dram_req_read, dram_req_write, dram_addr, dram_data_in});
    end
    if (w) dram_write_complete = 1'b1;
    else begin
      dram_data_out_valid = 1'b1;
      dram_data_out = rdata;
    end
    tick();
    dram_write_complete = 1'b0;
    dram_data_out_valid = 1'b0;
    chk("req_drop", {62'd0, dram_req_read, dram_req_write}, 64'd0);
    chk("busy_recover", {63'd0, busy}, 64'd1);
  endtask

  initial begin
    int t;
    logic [AW-1:0] a;
    logic w;
    logic [DW-1:0] din;
    logic [DW-1:0] rr_data [4];

    vecs[0] = '{1, 1'b0, 24'h000100, 32'h0,        32'h12345678, 4, 1'b0};
    vecs[1] = '{2, 1'b1, 24'h00FFFF, 32'hA5A5A5A5, 32'h0,        3, 1'b1};
    vecs[2] = '{2, 1'b0, 24'h000ABC, 32'h0,        32'hCAFEF00D, 0, 1'b0};
    vecs[3] = '{1, 1'b0, 24'hFFFFFF, 32'h0,        32'h0BADF00D, 2, 1'b1};
    vecs[4] = '{2, 1'b1, 24'h000000, 32'hFFFFFFFF, 32'h0,        1, 1'b0};
    vecs[5] = '{1, 1'b0, 24'h000001, 32'h0,        32'h00000001, 0, 1'b0};

    // Reset state.
    tick();
    tick();
    chk("rst_data", {data1, data_out2}, 64'd0);
    chk("rst_ctl", {2'd0, dram_addr, dram_data_in, data_valid1, data_valid2,
                    write_complete2, dram_req_read, dram_req_write, busy}, 64'd0);
`ifdef DRAM_ARB_TIMEOUT_EN
    chk("rst_terr", {63'd0, timeout_err}, 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Uncontended single transactions from the table.
    for (int i = 0; i < 6; i++) begin
      addr1      = vecs[i].addr;
      addr2      = vecs[i].addr;
      data_in2   = vecs[i].wdata;
      req_read1  = (vecs[i].port == 1);
      req_read2  = (vecs[i].port == 2) && !vecs[i].wr;
      req_write2 = (vecs[i].port == 2) && vecs[i].wr;
      push((vecs[i].port == 1) ? 2'd1 : (vecs[i].wr ? 2'd3 : 2'd2), vecs[i].rdata);
      serve(vecs[i].delay, vecs[i].rdata, vecs[i].noise, t, a, w, din);
      chk("latency", t, 64'd1);
      chk("dram_addr", {40'd0, a}, {40'd0, vecs[i].addr});
      chk("op", {63'd0, w}, {63'd0, vecs[i].wr});
      if (vecs[i].wr) chk("dram_data_in", {32'd0, din}, {32'd0, vecs[i].wdata});
      req_read1 = 1'b0;
      req_read2 = 1'b0;
      req_write2 = 1'b0;
      tick();
      chk("busy_idle", {63'd0, busy}, 64'd0);
    end
    chk("data_hold", {data1, data_out2}, {32'h00000001, 32'hCAFEF00D});

    // Reset while in READ. A late completion must be ignored.
    addr1 = 24'h000444;
    req_read1 = 1'b1;
    tick();
    chk("mid_read_req", {63'd0, dram_req_read}, 64'd1);
    tick();
    rst = 1'b1;
    req_read1 = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_data", {data1, data_out2}, 64'd0);
    chk("mid_rst_ctl", {2'd0, dram_addr, dram_data_in, data_valid1, data_valid2,
                        write_complete2, dram_req_read, dram_req_write, busy}, 64'd0);
    dram_data_out = 32'h11111111;
    dram_data_out_valid = 1'b1;
    tick();
    dram_data_out_valid = 1'b0;
    tick();
    chk("late_ignored", {data1, 31'd0, data_valid1}, 64'd0);

    // Both ports reading continuously: the grants must alternate 1,2,1,2.
    addr1 = 24'h000111;
    addr2 = 24'h000222;
    req_read1 = 1'b1;
    req_read2 = 1'b1;
    rr_data[0] = 32'h10000001;
    rr_data[1] = 32'h20000002;
    rr_data[2] = 32'h30000003;
    rr_data[3] = 32'h40000004;
    for (int j = 0; j < 4; j++) push((j % 2 == 0) ? 2'd1 : 2'd2, rr_data[j]);
    for (int j = 0; j < 4; j++) begin
      serve(1, rr_data[j], 1'b0, t, a, w, din);
      chk("rr_addr", {40'd0, a}, {40'd0, (j % 2 == 0) ? 24'h000111 : 24'h000222});
      chk("rr_latency", t, (j == 0) ? 64'd1 : 64'd2);
    end
    req_read1 = 1'b0;
    req_read2 = 1'b0;
    tick();

    // Port 2 read and write together: the write goes first, then the read.
    addr2 = 24'h000333;
    data_in2 = 32'h5A5A5A5A;
    req_read2 = 1'b1;
    req_write2 = 1'b1;
    push(2'd3, 32'h0);
    serve(2, 32'h0, 1'b0, t, a, w, din);
    chk("rw_first_write", {63'd0, w}, 64'd1);
    chk("rw_wdata", {32'd0, din}, {32'd0, 32'h5A5A5A5A});
    req_write2 = 1'b0;
    push(2'd2, 32'h77665544);
    serve(1, 32'h77665544, 1'b0, t, a, w, din);
    chk("rw_then_read", {63'd0, w}, 64'd0);
    chk("rw_read_latency", t, 64'd2);
    req_read2 = 1'b0;
    tick();

`ifdef DRAM_ARB_TIMEOUT_EN
    // The controller never answers: the pulse must come 17 cycles after the grant.
    addr1 = 24'h000555;
    req_read1 = 1'b1;
    push(2'd1, 32'hDEADBEEF);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k < 17) chk("tmo_wait", {62'd0, data_valid1, dram_req_read}, 64'd1);
      else        chk("tmo_pulse", {30'd0, data_valid1, timeout_err, data1}, {30'd0, 2'b11, 32'hDEADBEEF});
    end
    req_read1 = 1'b0;
    tick();
    chk("tmo_sticky", {62'd0, timeout_err, dram_req_read}, 64'd2);
`endif

    tick();
    chk("sb_empty", sb.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dram_rr_arbiter.md
Name: dram_rr_arbiter

Overview:
Two-port round-robin arbiter that shares the single SDRAM controller between two masters. Port 1 is a read-only streaming fetcher, such as the video/NTSC line fetcher. Port 2 is the CPU core, which issues reads and writes. The block sits between the masters and sdram_controller3, in the same position as bus_arbiter. It adds fair alternation, registered request capture and optional transaction timeout.

Parameters:
ADDR_W, 24, DRAM word address width
DATA_W, 32, data width on both master and DRAM sides
TIMEOUT, 255, cycles to wait for DRAM completion before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, 50 MHz domain
rst  in  1  synchronous reset, active-high
addr1  in  ADDR_W  port 1 read address
req_read1  in  1  port 1 read request, level, held until data_valid1
data1  out  DATA_W  port 1 read data
data_valid1  out  1  port 1 read-complete pulse
addr2  in  ADDR_W  port 2 address
data_in2  in  DATA_W  port 2 write data
req_read2  in  1  port 2 read request, level
req_write2  in  1  port 2 write request, level
data_out2  out  DATA_W  port 2 read data
data_valid2  out  1  port 2 read-complete pulse
write_complete2  out  1  port 2 write-complete pulse
dram_addr  out  ADDR_W  address to controller
dram_data_in  out  DATA_W  write data to controller
dram_req_read  out  1  read request to controller, level
dram_req_write  out  1  write request to controller, level
dram_data_out  in  DATA_W  read data from controller
dram_data_out_valid  in  1  controller read-done pulse
dram_write_complete  in  1  controller write-done pulse
busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - last_grant is 2, so port 1 wins the first contested arbitration.
- States: IDLE, READ, WRITE, RECOVER.
- IDLE grant rules:
  - Evaluated each cycle.
  - If only one port requests, that port is granted.
  - If both request, the port not equal to last_grant is granted.
  - Grant registers addr, write data, port id and op into internal registers. On the next cycle dram_req_read or dram_req_write goes high. IDLE→READ or WRITE.
- Port 2 op precedence: if req_read2 and req_write2 are both high, write wins and the read is serviced on a later grant.
- Controller request hold: dram_req_* stays high, with dram_addr and dram_data_in stable, until the matching completion pulse arrives.
  - In READ, only dram_data_out_valid is recognised.
  - In WRITE, only dram_write_complete is recognised.
  - A mismatched pulse is ignored.
- Completion cycle:
  - dram_req_* drops the same cycle (registered, so it is low on the following cycle).
  - dram_data_out is captured into data1 or data_out2.
  - On the next cycle, data_valid1, data_valid2 or write_complete2 pulses high for exactly 1 cycle.
  - last_grant is updated to the granted port. State→RECOVER.
- RECOVER lasts 1 cycle:
  - The completion pulse is presented to the master during this cycle.
  - Requests are ignored so a master can drop its req.
  - Then →IDLE.
- Latency: an uncontended request seen in IDLE at cycle 0 gives dram_req high at cycle 1. A completion at cycle N gives the master pulse at cycle N+1. The earliest next grant is at cycle N+2.
- Read data outputs hold their value until the next read for that port completes.
- A master dropping its req mid-transaction does not abort it. The transaction completes and the pulse is still issued.
- Reset mid-transaction returns to IDLE with dram_req_* low on the next cycle. Any in-flight controller completion arriving later is ignored in IDLE.
- Completion pulses arriving in IDLE or RECOVER are ignored.

Optional Feature:
Macro: DRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears at grant and increments in READ and WRITE.
  - On reaching TIMEOUT without completion, dram_req_* drops and the state goes to RECOVER.
  - The granted port receives its completion pulse. For reads, data is 32'hDEADBEEF.
  - A sticky output `timeout_err` (extra 1-bit port) sets to 1; it clears only on rst.
- Undefined: no counter and no timeout_err port; the arbiter waits indefinitely.

Test Plan:
- Reset, then port 1 reads addr 24'h000100 alone; controller returns 32'h12345678 after 5 cycles. Required: dram_req_read high from cycle 1 to completion, dram_addr=24'h000100, data1=32'h12345678, data_valid1 single pulse, data_valid2=0.
- Port 2 writes 32'hA5A5A5A5 to 24'h00FFFF. Required: dram_req_write high with dram_data_in=32'hA5A5A5A5 until dram_write_complete, then write_complete2 single pulse one cycle later.
- Both ports request reads continuously from reset. Required: grant order 1,2,1,2; dram_addr alternates between addr1 and addr2; each valid pulse goes only to its owner.
- Port 2 asserts req_read2 and req_write2 together. Required: write is serviced first; the read is granted on the following arbitration round.
- rst asserted while in READ. Required: next cycle state is IDLE, all outputs 0; a late dram_data_out_valid produces no data_valid pulse.
- With DRAM_ARB_TIMEOUT_EN and TIMEOUT=16, the controller never responds to a port 1 read. Required: data_valid1 pulses at grant+17 with data1=32'hDEADBEEF and timeout_err=1.
